// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter: takes one byte per valid/ready handshake and serialises it
// as start bit, eight data bits LSB first, stop bit, each bit CLK_DIV sclk cycles long.
module uart_tx_byte #(
  parameter int unsigned CLK_DIV = 434,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              bit_end;

  // State and datapath registers; reset aborts any frame and parks the line high
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign bit_end = (cnt_q == CNT_LAST);

  // Next-state and next-output logic; counter restarts at every bit boundary
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    busy_d  = busy_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (tx_valid) begin
          state_d = S_START;
          shreg_d = tx_data;
          idx_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx_ready = (state_q == S_IDLE);
  assign tx       = tx_q;
  assign busy     = busy_q;

endmodule
